// File: rtl/mdu_if.sv
// mdu_if: start/busy/done handshake and HI/LO result bus of the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, also written by MTHI/MTLO.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides stay radix-2 restoring.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc, acc_nx, prod;
    logic [WIDTH-1:0]   opnd, a_raw, a_mag, b_mag, quo, rem, hi_res, lo_res;
    logic [WIDTH:0]     psum, sh;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, b_zero, a_neg, b_neg;
    logic               accept, long_op, last, ge;

    assign accept  = bus.start && !bus.flush && state != RUN;
    assign long_op = !bus.op[2];
    assign a_neg   = !bus.op[0] && bus.a[WIDTH-1];
    assign b_neg   = !bus.op[0] && bus.b[WIDTH-1];
    assign a_mag   = a_neg ? -bus.a : bus.a;
    assign b_mag   = b_neg ? -bus.b : bus.b;
`ifdef MDU_FAST_MUL_EN
    assign last    = cnt == CW'(WIDTH - 1) || !is_div;
`else
    assign last    = cnt == CW'(WIDTH - 1);
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : '0};
        sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge     = sh >= {1'b0, opnd};
        acc_nx = is_div ? {ge ? WIDTH'(sh - {1'b0, opnd}) : sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                        : {psum, acc[WIDTH-1:1]};
`ifdef MDU_FAST_MUL_EN
        if (!is_div)
            acc_nx = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`endif
        prod   = neg_q ? -acc_nx : acc_nx;
        quo    = neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
        rem    = neg_r ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
        hi_res = !is_div ? prod[2*WIDTH-1:WIDTH] : b_zero ? a_raw : rem;
        lo_res = !is_div ? prod[WIDTH-1:0] : b_zero ? '1 : quo;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = bus.flush     ? IDLE :
                   state == RUN  ? (last ? DONE : RUN) :
                   accept && long_op ? RUN : IDLE;
    end

    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            opnd         <= '0;
            a_raw        <= '0;
            cnt          <= '0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            b_zero       <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.div_zero <= 1'b0;
        end else if (accept) begin
            if (long_op) begin
                is_div       <= bus.op[1];
                opnd         <= bus.op[1] ? b_mag : a_mag;
                acc          <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
                neg_q        <= a_neg ^ b_neg;
                neg_r        <= a_neg;
                b_zero       <= bus.b == '0;
                a_raw        <= bus.a;
                cnt          <= '0;
                bus.div_zero <= 1'b0;
            end
            if (bus.op == 3'b100) bus.hi <= bus.a;
            if (bus.op == 3'b101) bus.lo <= bus.a;
        end else if (state == RUN && !bus.flush) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                bus.hi <= hi_res;
                bus.lo <= lo_res;
                if (is_div && b_zero) bus.div_zero <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit against a cycle-level arithmetic model.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();
    mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo;
    logic [2*W:0] r_res;
    int           m_left;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {div_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [2*W:0] calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        p = '0;
        if (op[1] && b == '0)
            return {1'b1, a, {W{1'b1}}};
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: begin sq = sa / sb; sr = sa % sb; p = {sr[31:0], sq[31:0]}; end
            default: p = {32'(ua % ub), 32'(ua / ub)};
        endcase
        return {1'b0, p};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0; r_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (bus.flush) m_busy <= 1'b0;
                else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_dz, m_hi, m_lo} <= r_res;
                end else m_left <= m_left - 1;
            end else if (bus.start && !bus.flush) begin
                if (bus.op < 3'd4) begin
                    r_res  <= calc(bus.op, bus.a, bus.b);
                    m_busy <= 1'b1;
                    m_dz   <= 1'b0;
                    m_left <= bus.op[1] ? W : MUL_LAT;
                end else if (bus.op == 3'd4) m_hi <= bus.a;
                else if (bus.op == 3'd5) m_lo <= bus.a;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", W'(bus.busy), W'(m_busy));
            check("done", W'(bus.done), W'(m_done));
            check("div_zero", W'(bus.div_zero), W'(m_dz));
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < W + 8 && !bus.done; i++) @(negedge clk);
        check("done_seen", W'(bus.done), W'(1));
    endtask

    typedef struct { logic [2:0] op; logic [W-1:0] a, b; } vec_t;
    vec_t vecs[5] = '{
        '{3'd2, 32'd7,        32'hFFFFFFFE},
        '{3'd3, 32'hFFFFFFFF, 32'd10},
        '{3'd0, 32'h80000000, 32'h80000000},
        '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{3'd2, 32'h80000000, 32'd0}
    };

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, '0);
        check("rst_busy", W'(bus.busy), '0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        wait_done();
        check("mult_hi", bus.hi, 32'hFFFFFFFF);
        check("mult_lo", bus.lo, 32'hFFFFFFF1);
        issue(3'd1, 32'hFFFFFFFD, 32'd5);
        wait_done();
        check("multu_hi", bus.hi, 32'd4);
        check("multu_lo", bus.lo, 32'hFFFFFFF1);

        issue(3'd3, 32'd100, 32'd7);
        wait_done();
        check("divu_lo", bus.lo, 32'd14);
        check("divu_hi", bus.hi, 32'd2);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done();
        check("div_lo", bus.lo, 32'hFFFFFFFD);
        check("div_hi", bus.hi, 32'hFFFFFFFF);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done();
        check("divmin_lo", bus.lo, 32'h80000000);
        check("divmin_hi", bus.hi, 32'd0);

        issue(3'd2, 32'd9, 32'd0);
        wait_done();
        check("dz_lo", bus.lo, 32'hFFFFFFFF);
        check("dz_hi", bus.hi, 32'd9);
        check("dz_flag", W'(bus.div_zero), W'(1));
        issue(3'd1, 32'd3, 32'd4);
        check("dz_clear", W'(bus.div_zero), '0);
        wait_done();
        check("small_lo", bus.lo, 32'd12);

        issue(3'd0, 32'd7, 32'd9);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd5; bus.b = 32'd5;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", W'(bus.busy), '0);
        repeat (W + 2) @(negedge clk);
        check("flush_hi", bus.hi, 32'd0);
        check("flush_lo", bus.lo, 32'd12);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA5555;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_wins", bus.hi, 32'd0);

        issue(3'd1, 32'd2, 32'd3);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd5; bus.b = 32'd5;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        check("ignored_lo", bus.lo, 32'd6);

        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEADBEEF;
        @(negedge clk);
        bus.op = 3'd5; bus.a = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b0;
        check("mthi", bus.hi, 32'hDEADBEEF);
        check("mtlo", bus.lo, 32'h12345678);
        check("mt_done", W'(bus.done), '0);

        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_done();
        check("fast_hi", bus.hi, 32'd1);
        check("fast_lo", bus.lo, 32'hFFFFFFFE);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done();
        end
        check("tbl_dz_hi", bus.hi, 32'h80000000);

        issue(3'd2, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", bus.hi, '0);
        check("arst_lo", bus.lo, '0);
        check("arst_busy", W'(bus.busy), '0);
        check("arst_done", W'(bus.done), '0);
        check("arst_dz", W'(bus.div_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
